// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - round-robin scheduler sharing one pipelined multiplier among NREQ requesters
module mult_share_ctrl #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    parameter int LAT   = 2,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   op_a,
    input  logic [NREQ*WIDTH-1:0]   op_b,
    output logic [NREQ-1:0]         gnt,
    output logic [WIDTH-1:0]        mul_a,
    output logic [WIDTH-1:0]        mul_b,
    input  logic [2*WIDTH-1:0]      mul_y,
    output logic                    res_valid,
    output logic [IDW-1:0]          res_id,
    output logic [2*WIDTH-1:0]      res_y,
    output logic                    busy
);

    localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    logic [IDW-1:0]     rr_q, rr_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [WIDTH-1:0]   mul_b_q, mul_b_d;
    logic [LAT-1:0]     tag_v_q;
    logic [IDW-1:0]     tag_id_q [LAT];
    logic               res_valid_q;
    logic [IDW-1:0]     res_id_q;
    logic [2*WIDTH-1:0] res_y_q;

    logic [NREQ-1:0]    gnt_d;
    logic               win_d;
    logic [IDW-1:0]     win_id_d;
    logic [IDW:0]       idx;

    // Grant the first requester at or after rr_q, wrapping modulo NREQ; nothing while in reset
    always_comb begin
        gnt_d    = '0;
        win_d    = 1'b0;
        win_id_d = '0;
        idx      = '0;
        if (rst_n && enable) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = {1'b0, rr_q} + (IDW+1)'(k);
                if (idx >= NREQ_W) begin
                    idx = idx - NREQ_W;
                end
                if (!win_d && req[idx[IDW-1:0]]) begin
                    win_d                = 1'b1;
                    win_id_d             = idx[IDW-1:0];
                    gnt_d[idx[IDW-1:0]]  = 1'b1;
                end
            end
        end
    end

    // Issue next-state: operands and pointer move only when a grant is made
    always_comb begin
        rr_d    = rr_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (win_d) begin
            mul_a_d = op_a[win_id_d*WIDTH +: WIDTH];
            mul_b_d = op_b[win_id_d*WIDTH +: WIDTH];
            rr_d    = (win_id_d == LAST_ID) ? '0 : win_id_d + 1'b1;
        end
    end

    // Operand registers and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q    <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            rr_q    <= rr_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
        end
    end

    // Tag pipeline shadows the multiplier; last stage lines up with mul_y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            for (int s = LAT - 1; s > 0; s--) begin
                tag_v_q[s]  <= tag_v_q[s-1];
                tag_id_q[s] <= tag_id_q[s-1];
            end
            tag_v_q[0]  <= win_d;
            tag_id_q[0] <= win_id_d;
        end
    end

    // Result capture; id and product hold between pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_y_q     <= '0;
        end else begin
            res_valid_q <= tag_v_q[LAT-1];
            if (tag_v_q[LAT-1]) begin
                res_id_q <= tag_id_q[LAT-1];
                res_y_q  <= mul_y;
            end
        end
    end

    assign gnt       = gnt_d;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_y     = res_y_q;
    assign busy      = |tag_v_q;

endmodule
